uart_rom_loader: RTL and testbench

- Serial boot loader and the write side of the instruction ROM, which the core only reads.
- Receives a framed program image over UART (8N1), assembles little-endian 32-bit words and drives the ROM write port.
- Holds the core in reset while loading; releases it only after the checksum verifies.
- Sits beside the core top: drives rom wr_en/addr/data_i and the core reset.

---
 rtl/uart_rom_loader_pkg.sv | 27 ++
 rtl/uart_rom_loader_if.sv | 12 +
 rtl/uart_rx_byte.sv | 92 +++++++++
 rtl/uart_rom_loader.sv | 151 +++++++++++++++
 tb/tb_uart_rom_loader.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rom_loader_pkg.sv
// uart_rom_loader_pkg: shared constants and state encodings
// for the UART boot loader and its byte receiver.
package uart_rom_loader_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_L,
    LEN_H,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rom_loader_if.sv
// uart_rom_loader_if: ROM write port (wr_en strobe, byte addr, data).
// master = loader side, slave = ROM side.
interface uart_rom_loader_if;

  logic                                      wr_en;
  logic [uart_rom_loader_pkg::INST_ADDR_BUS-1:0] addr;
  logic [uart_rom_loader_pkg::INST_DATA_BUS-1:0] data;

  modport master (output wr_en, output addr, output data);
  modport slave  (input  wr_en, input  addr, input  data);

endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver. Ports: clk, rst, rx_i (async line),
// byte_valid/byte_data (good byte pulse), frame_err (stop bit low).
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  rx_state_e      st, st_n;
  logic           sync1, sync2, rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           sample;

  always_comb begin
    st_n   = st;
    sample = 1'b0;
    case (st)
      RX_START: sample = (cnt == CW'(HALF - 1));
      RX_DATA,
      RX_STOP:  sample = (cnt == CW'(DIV - 1));
      default:  sample = 1'b0;
    endcase
    case (st)
      RX_IDLE:
        if (rx_prev && !sync2) st_n = RX_START;
      RX_START:
        // line back high at mid start bit: glitch, not a start
        if (sample) st_n = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (sample && bit_cnt == 3'd7) st_n = RX_STOP;
      RX_STOP:
        if (sample) st_n = RX_IDLE;
      default:
        st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= RX_IDLE;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync1      <= rx_i;
      sync2      <= sync1;
      rx_prev    <= sync2;
      st         <= st_n;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (st == RX_IDLE || sample)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (st == RX_IDLE)
        bit_cnt <= '0;
      if (sample && st == RX_DATA) begin
        shift   <= {sync2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (sample && st == RX_STOP) begin
        if (sync2) begin
          byte_valid <= 1'b1;
          byte_data  <= shift;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: UART boot loader; writes framed image into ROM.
// Ports: clk, rst, uart_rx_i, rom (write port), cpu_rst_o, busy_o, done_o, err_o.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 115200,
  parameter int DEPTH_WORDS = 4096,
  parameter int TIMEOUT_CYC = 5000000,
  parameter int BOOT_HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_i,
  uart_rom_loader_if.master rom,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  logic        byte_valid;
  logic        frame_err;
  logic [7:0]  byte_data;

  ld_state_e   state, state_n;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  k;
  logic [23:0] word_lo;
  logic [7:0]  acc;
  logic [31:0] to_cnt;
  logic        in_frame;
  logic        busy_n;
  logic        timeout;
  logic        take;
  logic [15:0] len_full;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (uart_rx_i),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always_comb begin
    in_frame = (state == LEN_L) || (state == LEN_H) ||
               (state == DATA)  || (state == CSUM);
    timeout  = in_frame && (to_cnt == 32'(TIMEOUT_CYC));
    take     = byte_valid && !timeout;
    len_full = {byte_data, len[7:0]};
    state_n  = state;
    if (in_frame && (frame_err || timeout)) begin
      state_n = ERR;
    end else if (byte_valid) begin
      case (state)
        IDLE, DONE, ERR:
          if (byte_data == SYNC_BYTE) state_n = LEN_L;
        LEN_L:
          state_n = LEN_H;
        LEN_H:
          if (32'(len_full) > 32'(DEPTH_WORDS))
            state_n = ERR;
          else if (len_full == '0)
            state_n = CSUM;
          else
            state_n = DATA;
        DATA:
          if (k == 2'd3 && idx == len - 16'd1)
            state_n = CSUM;
        CSUM:
          state_n = (byte_data == acc) ? DONE : ERR;
        default:
          state_n = ERR;
      endcase
    end
    busy_n = (state_n == LEN_L) || (state_n == LEN_H) ||
             (state_n == DATA)  || (state_n == CSUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom.wr_en <= 1'b0;
      rom.addr  <= '0;
      rom.data  <= '0;
      cpu_rst_o <= (BOOT_HOLD != 0);
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      len       <= '0;
      idx       <= '0;
      k         <= '0;
      word_lo   <= '0;
      acc       <= '0;
      to_cnt    <= '0;
    end else begin
      rom.wr_en <= 1'b0;
      busy_o    <= busy_n;
      done_o    <= (state_n == DONE);
      err_o     <= (state_n == ERR);
      // IDLE is only left via a sync byte, so it only ever
      // reflects the post-reset hold policy
      cpu_rst_o <= (state_n == IDLE) ? (BOOT_HOLD != 0)
                                     : (state_n != DONE);
      if (!in_frame || byte_valid)
        to_cnt <= '0;
      else if (!timeout)
        to_cnt <= to_cnt + 32'd1;
      if (take) begin
        case (state)
          IDLE, DONE, ERR:
            if (byte_data == SYNC_BYTE) begin
              idx <= '0;
              k   <= '0;
              acc <= '0;
            end
          LEN_L:
            len[7:0] <= byte_data;
          LEN_H:
            len[15:8] <= byte_data;
          DATA: begin
            acc <= acc ^ byte_data;
            k   <= k + 2'd1;
            if (k == 2'd3) begin
              rom.wr_en <= 1'b1;
              rom.addr  <= INST_ADDR_BUS'(idx) << 2;
              rom.data  <= {byte_data, word_lo};
              idx       <= idx + 16'd1;
            end else begin
              // bytes arrive LSB first; after three shifts
              // word_lo holds {b2, b1, b0}
              word_lo <= {byte_data, word_lo[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed bench for uart_rom_loader
// with DIV=16 and a short inter-byte timeout.
module tb_uart_rom_loader;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TMO      = 400;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic cpu_rst, busy, done, err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bv_cyc   = 0;
  int fall_cyc = 0;
  int base;
  logic cpu_rst_q = 1'b1;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  uart_rom_loader_if rom_if ();

  uart_rom_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .DEPTH_WORDS (4096),
    .TIMEOUT_CYC (TMO),
    .BOOT_HOLD   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx_i (rx),
    .rom       (rom_if),
    .cpu_rst_o (cpu_rst),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rom_if.wr_en === 1'b1) begin
      wa.push_back(rom_if.addr);
      wd.push_back(rom_if.data);
    end
    if (dut.byte_valid === 1'b1) bv_cyc = cyc;
    if (cpu_rst_q === 1'b1 && cpu_rst === 1'b0) fall_cyc = cyc;
    cpu_rst_q = cpu_rst;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (DIV) @(negedge clk);
  endtask

  // v holds the bytes in send order, first byte most significant
  task automatic send_bytes(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++)
      send_byte(v[8*(n-1-i) +: 8], 1'b1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_wr_en",   32'(rom_if.wr_en), 32'd0);
    rst = 1'b0;

    // 1: idle line after reset
    repeat (10000) @(negedge clk);
    check("t1_writes",  32'(wa.size()), 32'd0);
    check("t1_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t1_busy",    32'(busy), 32'd0);
    check("t1_done",    32'(done), 32'd0);
    check("t1_err",     32'(err), 32'd0);
    check("t1_addr",    rom_if.addr, 32'd0);
    check("t1_data",    rom_if.data, 32'd0);

    // 2: two-word good frame
    base = wa.size();
    send_bytes(128'hA5_02_00_13_00_00_00_93_00_10_00_90, 12);
    check("t2_writes", 32'(wa.size() - base), 32'd2);
    check("t2_a0", wa[base],   32'h0);
    check("t2_d0", wd[base],   32'h00000013);
    check("t2_a1", wa[base+1], 32'h4);
    check("t2_d1", wd[base+1], 32'h00100093);
    check("t2_done",    32'(done), 32'd1);
    check("t2_err",     32'(err), 32'd0);
    check("t2_busy",    32'(busy), 32'd0);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t2_fall_lat", 32'(fall_cyc - bv_cyc), 32'd1);
    check("t2_addr_hold", rom_if.addr, 32'h4);
    check("t2_data_hold", rom_if.data, 32'h00100093);

    // 3: bad checksum, then a good reload
    base = wa.size();
    send_bytes(128'hA5_02_00_13_00_00_00_93_00_10_00_91, 12);
    check("t3_writes",  32'(wa.size() - base), 32'd2);
    check("t3_d1",      wd[base+1], 32'h00100093);
    check("t3_err",     32'(err), 32'd1);
    check("t3_done",    32'(done), 32'd0);
    check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    send_bytes(128'hA5_02_00_13_00_00_00_93_00_10_00_90, 12);
    check("t3_re_done", 32'(done), 32'd1);
    check("t3_re_err",  32'(err), 32'd0);
    check("t3_re_cpu",  32'(cpu_rst), 32'd0);

    // 4: garbage then empty frame
    base = wa.size();
    send_bytes(128'h00_FF_5A_A5_00_00_00, 7);
    check("t4_writes",  32'(wa.size() - base), 32'd0);
    check("t4_done",    32'(done), 32'd1);
    check("t4_err",     32'(err), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd0);

    // 5a: framing error on a data byte
    base = wa.size();
    send_bytes(128'hA5_01_00, 3);
    send_byte(8'h11, 1'b0);
    repeat (10) @(negedge clk);
    check("t5a_writes",  32'(wa.size() - base), 32'd0);
    check("t5a_err",     32'(err), 32'd1);
    check("t5a_busy",    32'(busy), 32'd0);
    check("t5a_cpu_rst", 32'(cpu_rst), 32'd1);

    // 5b: inter-byte timeout
    send_bytes(128'hA5_01_00, 3);
    repeat (290) @(negedge clk);
    check("t5b_busy_pre", 32'(busy), 32'd1);
    check("t5b_err_pre",  32'(err), 32'd0);
    repeat (150) @(negedge clk);
    check("t5b_err",  32'(err), 32'd1);
    check("t5b_busy", 32'(busy), 32'd0);

    // 6a: length beyond ROM depth
    base = wa.size();
    send_bytes(128'hA5_01_10, 3);
    check("t6a_err",    32'(err), 32'd1);
    check("t6a_busy",   32'(busy), 32'd0);
    check("t6a_writes", 32'(wa.size() - base), 32'd0);

    // 6b: async reset in the middle of the data phase
    send_bytes(128'hA5_02_00_13_00_00_00_93_00, 9);
    check("t6b_busy_pre", 32'(busy), 32'd1);
    check("t6b_data_pre", rom_if.data, 32'h00000013);
    #2;
    rst = 1'b1;
    #1;
    check("t6b_data",    rom_if.data, 32'd0);
    check("t6b_addr",    rom_if.addr, 32'd0);
    check("t6b_busy",    32'(busy), 32'd0);
    check("t6b_done",    32'(done), 32'd0);
    check("t6b_err",     32'(err), 32'd0);
    check("t6b_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = wa.size();
    repeat (300) @(negedge clk);
    check("t6b_no_write", 32'(wa.size() - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
